// File: rtl/leg_solver_pkg.sv
// Shared types and defaults for the leg solver slice.
package leg_pkg;

  localparam int W_DEF    = 16;
  localparam int ITER_DEF = W_DEF;
  localparam int CNT_W    = $clog2(ITER_DEF);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

endpackage

// File: rtl/leg_solver_if.sv
// Start/done handshake bundle between the leg solver and its requester.
interface leg_solver_if #(
  parameter int W  = leg_pkg::W_DEF,
  parameter int CW = leg_pkg::CNT_W
);

  logic          start;
  logic [W-1:0]  inC;
  logic [W-1:0]  inA;
  logic [W-1:0]  out;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, inC, inA,
    input  out, count, busy, done, err
  );

  modport slave (
    input  start, inC, inA,
    output out, count, busy, done, err
  );

endinterface

// File: rtl/leg_solver_isqrt_iter.sv
// Restoring digit-by-digit square root of a 2W-bit value, two bits per step.
module isqrt_iter #(
  parameter int W = leg_pkg::W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [2*W-1:0] d,
  input  logic           step,
  output logic [W-1:0]   root,
  output logic [W+1:0]   rem
);

  logic [2*W-1:0] d_shift;
  logic [W+3:0]   cur;
  logic [W+3:0]   sub;
  logic [W+1:0]   trial;
  logic           ge;

  // Remainder with the next radicand pair appended, against (root<<2 | 1).
  // The restored remainder never exceeds 2*root, so W+2 bits hold it and
  // the subtraction only needs those low bits once ge is known.
  assign cur   = {rem, d_shift[2*W-1 -: 2]};
  assign sub   = {2'b00, root, 2'b01};
  assign ge    = (cur >= sub);
  assign trial = cur[W+1:0] - sub[W+1:0];

  // Load clears the root and remainder; each step consumes the top two bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_shift <= '0;
      root    <= '0;
      rem     <= '0;
    end else if (load) begin
      d_shift <= d;
      root    <= '0;
      rem     <= '0;
    end else if (step) begin
      d_shift <= {d_shift[2*W-3:0], 2'b00};
      rem     <= ge ? trial : cur[W+1:0];
      root    <= {root[W-2:0], ge};
    end
  end

endmodule

// File: rtl/leg_solver.sv
// Leg solver: B = floor(sqrt(C*C - A*A)) with a start/done handshake.
// Optional build macro LEG_ROUND_EN rounds the result to nearest.
module leg_solver
  import leg_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int ITER = W
) (
  input  logic         clk,
  input  logic         reset,
  leg_solver_if.slave  bus
);

  localparam int CW = $clog2(ITER);
  localparam int DW = 2 * W;

  state_t        state;
  state_t        next_state;

  logic [W-1:0]  c_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  out_reg;
  logic          err_reg;
  logic [CW-1:0] cnt;

  logic [DW-1:0] c_sq;
  logic [DW-1:0] a_sq;
  logic          c_lt_a;
  logic [DW-1:0] d_val;

  logic          core_load;
  logic          core_step;
  logic [W-1:0]  root;
  logic [W+1:0]  rem;
  logic [W-1:0]  final_val;

  // Difference of squares at full 2W width; an impossible triangle feeds 0.
  assign c_sq   = DW'(c_reg) * DW'(c_reg);
  assign a_sq   = DW'(a_reg) * DW'(a_reg);
  assign c_lt_a = (c_reg < a_reg);
  assign d_val  = c_lt_a ? '0 : (c_sq - a_sq);

  isqrt_iter #(.W(W)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .d     (d_val),
    .step  (core_step),
    .root  (root),
    .rem   (rem)
  );

`ifdef LEG_ROUND_EN
  // Round up when the remainder exceeds the root, saturating at all ones.
  always_comb begin
    final_val = root;
    if (err_reg) begin
      final_val = '0;
    end else if ((rem > {2'b00, root}) && (root != '1)) begin
      final_val = root + 1'b1;
    end
  end
`else
  logic unused_rem;
  assign unused_rem = ^rem;
  assign final_val  = err_reg ? '0 : root;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one operation in flight, start only seen in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SQUARE;
      SQUARE:  next_state = ROOT;
      ROOT:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; the result register holds between launches.
  always_comb begin
    core_load = (state == SQUARE);
    core_step = (state == ROOT);
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    bus.err   = (state == DONE) && err_reg;
    bus.count = (state == ROOT) ? cnt : '0;
    bus.out   = (state == DONE) ? final_val : out_reg;
  end

  // Operand capture, error flag, iteration counter and result hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_reg   <= '0;
      a_reg   <= '0;
      err_reg <= 1'b0;
      cnt     <= '0;
      out_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            c_reg <= bus.inC;
            a_reg <= bus.inA;
          end
        end
        SQUARE: begin
          err_reg <= c_lt_a;
          cnt     <= CW'(ITER - 1);
        end
        ROOT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          out_reg <= final_val;
        end
        default: ;
      endcase
    end
  end

endmodule
